// File: rtl/acquisition_sequencer_if.sv
// Bundle of the register bus, sample/trigger strobes, channel Tx streams and
// the muxed Tx stream around the acquisition sequencer.
// master: the sequencer side. slave: the surrounding system (channels,
// trigger logic, register bus, Tx protocol block).
interface acquisition_sequencer_if #(
  parameter int REG_ADDR_WIDTH = 8,
  parameter int REG_DATA_WIDTH = 16,
  parameter int TX_DATA_WIDTH  = 8
);
  logic [REG_ADDR_WIDTH-1:0] register_addr;
  logic [REG_DATA_WIDTH-1:0] register_data;
  logic                      register_rdy;
  logic                      sample_rdy;
  logic                      trigger;
  logic                      we;
  logic [15:0]               num_samples;
  logic                      rqst_data_ch1;
  logic                      rqst_data_ch2;
  logic [TX_DATA_WIDTH-1:0]  ch1_tx_data;
  logic [TX_DATA_WIDTH-1:0]  ch2_tx_data;
  logic                      ch1_tx_rdy;
  logic                      ch2_tx_rdy;
  logic                      ch1_tx_eof;
  logic                      ch2_tx_eof;
  logic                      ch1_tx_ack;
  logic                      ch2_tx_ack;
  logic [TX_DATA_WIDTH-1:0]  tx_data;
  logic                      tx_rdy;
  logic                      tx_eof;
  logic                      tx_ack;
  logic                      busy;
  logic                      triggered;

  modport master (
    input  register_addr, register_data, register_rdy, sample_rdy, trigger,
    input  ch1_tx_data, ch2_tx_data, ch1_tx_rdy, ch2_tx_rdy,
    input  ch1_tx_eof, ch2_tx_eof, tx_ack,
    output we, num_samples, rqst_data_ch1, rqst_data_ch2,
    output ch1_tx_ack, ch2_tx_ack, tx_data, tx_rdy, tx_eof, busy, triggered
  );

  modport slave (
    output register_addr, register_data, register_rdy, sample_rdy, trigger,
    output ch1_tx_data, ch2_tx_data, ch1_tx_rdy, ch2_tx_rdy,
    output ch1_tx_eof, ch2_tx_eof, tx_ack,
    input  we, num_samples, rqst_data_ch1, rqst_data_ch2,
    input  ch1_tx_ack, ch2_tx_ack, tx_data, tx_rdy, tx_eof, busy, triggered
  );
endinterface

// File: rtl/acquisition_sequencer.sv
// Acquisition sequencer: arms RAM writes, counts pre-/post-trigger samples,
// then requests each enabled channel buffer in turn and muxes the channel Tx
// streams onto the single Tx protocol interface.
// Optional macro CONTINUOUS_MODE_EN: bit4 of the command register selects
// auto re-arm after readout instead of returning to idle.
module acquisition_sequencer #(
  parameter int REG_ADDR_WIDTH      = 8,
  parameter int REG_DATA_WIDTH      = 16,
  parameter int TX_DATA_WIDTH       = 8,
  parameter int RAM_SIZE            = 4096,
  parameter int ADDR_REQUESTS       = 8,
  parameter int ADDR_NUM_SAMPLES    = 9,
  parameter int ADDR_PRETRIGGER     = 10,
  parameter int DEFAULT_NUM_SAMPLES = 1024,
  parameter int DEFAULT_PRETRIGGER  = 512
) (
  input logic                    clk,
  input logic                    rst,
  acquisition_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILL_PRE  = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_FILL_POST = 3'd3,
    ST_SEND      = 3'd4
  } state_t;

  localparam logic [15:0] RAM_LIMIT = 16'(RAM_SIZE);

  // Saturate a sample count at a limit.
  function automatic logic [15:0] clamp16(input logic [15:0] value, input logic [15:0] limit);
    return (value > limit) ? limit : value;
  endfunction

  state_t      state_r, state_next_s;
  logic [15:0] cnt_r, cnt_next_s, cnt_inc_s;
  logic [15:0] num_reg_r, pre_reg_r;
  logic [15:0] num_samples_r, pre_sh_r, post_s;
  logic        ch1_en_r, ch2_en_r;
  logic        we_r, busy_r, triggered_r, trig_next_s;
  logic        rqst1_r, rqst2_r, rqst1_next_s, rqst2_next_s;
  logic        sel_r, sel_next_s, sel_vld_r, sel_vld_next_s;
  logic        enter_send_s, finish_s;
  logic        cmd_wr_s, start_s, stop_s;
  logic        pre_reach_s, post_reach_s;
  logic        in_send_s, sel_rdy_s, sel_eof_s, last_s, xfer_done_s;
  logic [REG_DATA_WIDTH-1:0] reg_data_s;
  logic [15:0] reg_word_s;
`ifdef CONTINUOUS_MODE_EN
  logic        cont_r;
`endif

  assign reg_data_s = bus.register_data;
  assign reg_word_s = 16'(reg_data_s);
  assign cmd_wr_s   = bus.register_rdy && (bus.register_addr == REG_ADDR_WIDTH'(ADDR_REQUESTS));
  // Stop wins over start when both bits arrive in one write.
  assign start_s    = cmd_wr_s && reg_word_s[0] && !reg_word_s[1];
  assign stop_s     = cmd_wr_s && reg_word_s[1];

  // post never underflows: the shadowed pretrigger is clamped to num_samples.
  assign post_s       = num_samples_r - pre_sh_r;
  assign cnt_inc_s    = cnt_r + {15'd0, bus.sample_rdy};
  // Target reached either already or by the sample arriving this cycle, so
  // the state moves on the same edge that takes the final sample.
  assign pre_reach_s  = (cnt_r == pre_sh_r) || (bus.sample_rdy && ((cnt_r + 16'd1) == pre_sh_r));
  assign post_reach_s = (cnt_r == post_s)   || (bus.sample_rdy && ((cnt_r + 16'd1) == post_s));

  assign in_send_s   = (state_r == ST_SEND) && sel_vld_r;
  assign sel_rdy_s   = sel_r ? bus.ch2_tx_rdy : bus.ch1_tx_rdy;
  assign sel_eof_s   = sel_r ? bus.ch2_tx_eof : bus.ch1_tx_eof;
  // ch2 is always last when selected; ch1 is last only if ch2 is disabled.
  assign last_s      = sel_r || !ch2_en_r;
  assign xfer_done_s = in_send_s && sel_rdy_s && bus.tx_ack && sel_eof_s;

  // Tx stream is a combinational pass-through of the selected channel.
  assign bus.tx_data    = in_send_s ? (sel_r ? bus.ch2_tx_data : bus.ch1_tx_data)
                                    : {TX_DATA_WIDTH{1'b0}};
  assign bus.tx_rdy     = in_send_s && sel_rdy_s;
  assign bus.tx_eof     = in_send_s && sel_rdy_s && sel_eof_s && last_s;
  assign bus.ch1_tx_ack = in_send_s && !sel_r && bus.tx_ack;
  assign bus.ch2_tx_ack = in_send_s &&  sel_r && bus.tx_ack;

  assign bus.we            = we_r;
  assign bus.busy          = busy_r;
  assign bus.triggered     = triggered_r;
  assign bus.rqst_data_ch1 = rqst1_r;
  assign bus.rqst_data_ch2 = rqst2_r;
  assign bus.num_samples   = num_samples_r;

  // Configuration registers; capture sizes are shadowed while idle only.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_reg_r     <= 16'(DEFAULT_NUM_SAMPLES);
      pre_reg_r     <= 16'(DEFAULT_PRETRIGGER);
      num_samples_r <= clamp16(16'(DEFAULT_NUM_SAMPLES), RAM_LIMIT);
      pre_sh_r      <= clamp16(16'(DEFAULT_PRETRIGGER),
                               clamp16(16'(DEFAULT_NUM_SAMPLES), RAM_LIMIT));
      ch1_en_r      <= 1'b1;
      ch2_en_r      <= 1'b1;
`ifdef CONTINUOUS_MODE_EN
      cont_r        <= 1'b0;
`endif
    end else begin
      if (bus.register_rdy && (bus.register_addr == REG_ADDR_WIDTH'(ADDR_NUM_SAMPLES))) begin
        num_reg_r <= reg_word_s;
      end
      if (bus.register_rdy && (bus.register_addr == REG_ADDR_WIDTH'(ADDR_PRETRIGGER))) begin
        pre_reg_r <= reg_word_s;
      end
      if (cmd_wr_s) begin
        ch1_en_r <= reg_word_s[2];
        ch2_en_r <= reg_word_s[3];
`ifdef CONTINUOUS_MODE_EN
        cont_r   <= reg_word_s[4];
`endif
      end
      if (state_r == ST_IDLE) begin
        num_samples_r <= clamp16(num_reg_r, RAM_LIMIT);
        pre_sh_r      <= clamp16(pre_reg_r, clamp16(num_reg_r, RAM_LIMIT));
      end
    end
  end

  // Next-state, counter, channel selection and request pulses.
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = cnt_r;
    sel_next_s     = sel_r;
    sel_vld_next_s = sel_vld_r;
    rqst1_next_s   = 1'b0;
    rqst2_next_s   = 1'b0;
    trig_next_s    = triggered_r;
    enter_send_s   = 1'b0;
    finish_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        trig_next_s    = 1'b0;
        sel_vld_next_s = 1'b0;
        if (start_s) begin
          state_next_s = ST_FILL_PRE;
          cnt_next_s   = 16'd0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_FILL_PRE: begin
        cnt_next_s = cnt_inc_s;
        if (pre_reach_s) begin
          state_next_s = ST_WAIT_TRIG;
        end else begin
          state_next_s = ST_FILL_PRE;
        end
      end
      ST_WAIT_TRIG: begin
        if (bus.trigger) begin
          trig_next_s = 1'b1;
          cnt_next_s  = 16'd0;
          if (post_s == 16'd0) begin
            enter_send_s = 1'b1;
          end else begin
            state_next_s = ST_FILL_POST;
          end
        end else begin
          state_next_s = ST_WAIT_TRIG;
        end
      end
      ST_FILL_POST: begin
        cnt_next_s = cnt_inc_s;
        if (post_reach_s) begin
          enter_send_s = 1'b1;
        end else begin
          state_next_s = ST_FILL_POST;
        end
      end
      ST_SEND: begin
        if (!sel_vld_r) begin
          finish_s = 1'b1;
        end else if (xfer_done_s) begin
          if (!sel_r && ch2_en_r) begin
            sel_next_s   = 1'b1;
            rqst2_next_s = 1'b1;
          end else begin
            finish_s = 1'b1;
          end
        end else begin
          state_next_s = ST_SEND;
        end
      end
      default: begin
        state_next_s   = ST_IDLE;
        trig_next_s    = 1'b0;
        sel_vld_next_s = 1'b0;
      end
    endcase

    if (enter_send_s) begin
      state_next_s = ST_SEND;
      if (ch1_en_r) begin
        sel_next_s     = 1'b0;
        sel_vld_next_s = 1'b1;
        rqst1_next_s   = 1'b1;
      end else if (ch2_en_r) begin
        sel_next_s     = 1'b1;
        sel_vld_next_s = 1'b1;
        rqst2_next_s   = 1'b1;
      end else begin
        sel_vld_next_s = 1'b0;
      end
    end else begin
      sel_vld_next_s = sel_vld_next_s;
    end

    if (finish_s) begin
      sel_vld_next_s = 1'b0;
      trig_next_s    = 1'b0;
`ifdef CONTINUOUS_MODE_EN
      if (cont_r) begin
        state_next_s = ST_FILL_PRE;
        cnt_next_s   = 16'd0;
      end else begin
        state_next_s = ST_IDLE;
      end
`else
      state_next_s = ST_IDLE;
`endif
    end else begin
      trig_next_s = trig_next_s;
    end

    if (stop_s) begin
      state_next_s   = ST_IDLE;
      rqst1_next_s   = 1'b0;
      rqst2_next_s   = 1'b0;
      trig_next_s    = 1'b0;
      sel_vld_next_s = 1'b0;
    end else begin
      state_next_s = state_next_s;
    end
  end

  // State register and registered status/control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 16'd0;
      sel_r       <= 1'b0;
      sel_vld_r   <= 1'b0;
      rqst1_r     <= 1'b0;
      rqst2_r     <= 1'b0;
      triggered_r <= 1'b0;
      we_r        <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cnt_r       <= cnt_next_s;
      sel_r       <= sel_next_s;
      sel_vld_r   <= sel_vld_next_s;
      rqst1_r     <= rqst1_next_s;
      rqst2_r     <= rqst2_next_s;
      triggered_r <= trig_next_s;
      we_r        <= (state_next_s == ST_FILL_PRE) || (state_next_s == ST_WAIT_TRIG) ||
                     (state_next_s == ST_FILL_POST);
      busy_r      <= (state_next_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_acquisition_sequencer.sv
// Directed bench for acquisition_sequencer: a per-cycle vector table for the
// capture window plus hand-written readout, clamp, stop and channel-enable
// sequences.
module tb_acquisition_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  acquisition_sequencer_if bus ();

  acquisition_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rr;
    logic [7:0]  addr;
    logic [15:0] data;
    logic        smp;
    logic        trg;
    logic        e_we;
    logic        e_busy;
    logic        e_trig;
    logic        e_rq1;
    logic        e_rq2;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [15:0] data);
    bus.register_rdy  = 1'b1;
    bus.register_addr = addr;
    bus.register_data = data;
    tick();
    bus.register_rdy  = 1'b0;
  endtask

  task automatic smp();
    bus.sample_rdy = 1'b1;
    tick();
    bus.sample_rdy = 1'b0;
  endtask

  task automatic trg();
    bus.trigger = 1'b1;
    tick();
    bus.trigger = 1'b0;
  endtask

  task automatic clr_tx();
    bus.ch1_tx_rdy = 1'b0; bus.ch1_tx_eof = 1'b0; bus.ch1_tx_data = 8'h00;
    bus.ch2_tx_rdy = 1'b0; bus.ch2_tx_eof = 1'b0; bus.ch2_tx_data = 8'h00;
    bus.tx_ack     = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  32'(bus.busy), 32'd0);
    chk({tag, "_we"},    32'(bus.we), 32'd0);
    chk({tag, "_trig"},  32'(bus.triggered), 32'd0);
    chk({tag, "_rq"},    32'({bus.rqst_data_ch1, bus.rqst_data_ch2}), 32'd0);
    chk({tag, "_txrdy"}, 32'(bus.tx_rdy), 32'd0);
    chk({tag, "_txeof"}, 32'(bus.tx_eof), 32'd0);
    chk({tag, "_acks"},  32'({bus.ch1_tx_ack, bus.ch2_tx_ack}), 32'd0);
  endtask

  initial begin
    int rq1_cnt;
    int rq2_cnt;
    int ack1_seen;

    bus.register_rdy = 1'b0; bus.register_addr = 8'h00; bus.register_data = 16'h0000;
    bus.sample_rdy   = 1'b0; bus.trigger = 1'b0;
    clr_tx();

    // rr addr data smp trg | we busy trig rq1 rq2
    tbl[0]  = '{1'b1, 8'd9,  16'd8,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'd10, 16'd3,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 8'd8,  16'h000D,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 8'd0,  16'd0,     1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 8'd0,  16'd0,     1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 8'd0,  16'd0,     1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 8'd0,  16'd0,     1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 8'd0,  16'd0,     1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 8'd0,  16'd0,     1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 8'd0,  16'd0,     1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 8'd0,  16'd0,     1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 8'd0,  16'd0,     1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 8'd0,  16'd0,     1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 8'd0,  16'd0,     1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 8'd0,  16'd0,     1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_idle("rst");
    chk("rst_num", 32'(bus.num_samples), 32'd1024);
    rst = 1'b0;

    // Capture window: num=8, pre=3, early trigger ignored, 5 post samples
    for (int i = 0; i < NV; i++) begin
      bus.register_rdy  = tbl[i].rr;
      bus.register_addr = tbl[i].addr;
      bus.register_data = tbl[i].data;
      bus.sample_rdy    = tbl[i].smp;
      bus.trigger       = tbl[i].trg;
      tick();
      bus.register_rdy = 1'b0; bus.sample_rdy = 1'b0; bus.trigger = 1'b0;
      chk($sformatf("v%0d_we", i),   32'(bus.we),            32'(tbl[i].e_we));
      chk($sformatf("v%0d_busy", i), 32'(bus.busy),          32'(tbl[i].e_busy));
      chk($sformatf("v%0d_trig", i), 32'(bus.triggered),     32'(tbl[i].e_trig));
      chk($sformatf("v%0d_rq1", i),  32'(bus.rqst_data_ch1), 32'(tbl[i].e_rq1));
      chk($sformatf("v%0d_rq2", i),  32'(bus.rqst_data_ch2), 32'(tbl[i].e_rq2));
    end
    chk("num8", 32'(bus.num_samples), 32'd8);

    // Readout: ch1 then ch2, 8 bytes each, eof only forwarded for ch2
    rq1_cnt = 0; rq2_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      bus.ch1_tx_rdy = 1'b1; bus.ch1_tx_data = 8'h10 + 8'(i);
      bus.ch1_tx_eof = (i == 7); bus.tx_ack = 1'b1;
      #1;
      rq1_cnt += int'(bus.rqst_data_ch1); rq2_cnt += int'(bus.rqst_data_ch2);
      chk($sformatf("c1b%0d_rdy", i),  32'(bus.tx_rdy), 32'd1);
      chk($sformatf("c1b%0d_data", i), 32'(bus.tx_data), 32'h10 + 32'(i));
      chk($sformatf("c1b%0d_eof", i),  32'(bus.tx_eof), 32'd0);
      chk($sformatf("c1b%0d_ack", i),  32'({bus.ch1_tx_ack, bus.ch2_tx_ack}), 32'b10);
      tick();
    end
    clr_tx();
    for (int i = 0; i < 8; i++) begin
      bus.ch2_tx_rdy = 1'b1; bus.ch2_tx_data = 8'h20 + 8'(i);
      bus.ch2_tx_eof = (i == 7); bus.tx_ack = 1'b1;
      #1;
      rq1_cnt += int'(bus.rqst_data_ch1); rq2_cnt += int'(bus.rqst_data_ch2);
      chk($sformatf("c2b%0d_data", i), 32'(bus.tx_data), 32'h20 + 32'(i));
      chk($sformatf("c2b%0d_eof", i),  32'(bus.tx_eof), (i == 7) ? 32'd1 : 32'd0);
      chk($sformatf("c2b%0d_ack", i),  32'({bus.ch1_tx_ack, bus.ch2_tx_ack}), 32'b01);
      tick();
    end
    clr_tx();
    #1;
    chk("rq1_pulses", 32'(rq1_cnt), 32'd1);
    chk("rq2_pulses", 32'(rq2_cnt), 32'd1);
    chk_idle("done1");

    // Clamp: num=5000 -> 4096, pre=6000 -> 4096, post=0 goes straight to SEND
    wr(8'd9, 16'd5000);
    wr(8'd10, 16'd6000);
    tick();
    chk("num_clamp", 32'(bus.num_samples), 32'd4096);
    wr(8'd8, 16'h000D);
    repeat (4095) smp();
    trg();
    chk("clamp_trig_early", 32'(bus.triggered), 32'd0);
    chk("clamp_busy", 32'(bus.busy), 32'd1);
    smp();
    trg();
    chk("clamp_trig", 32'(bus.triggered), 32'd1);
    chk("clamp_we", 32'(bus.we), 32'd0);
    chk("clamp_rq1", 32'(bus.rqst_data_ch1), 32'd1);

    // Stop mid-SEND after three ch1 bytes
    for (int i = 0; i < 3; i++) begin
      bus.ch1_tx_rdy = 1'b1; bus.ch1_tx_data = 8'h40 + 8'(i); bus.tx_ack = 1'b1;
      tick();
    end
    wr(8'd8, 16'h000E);
    bus.ch1_tx_eof = 1'b1;
    #1;
    chk_idle("stop_send");
    clr_tx();

    // Stop during FILL_POST
    wr(8'd9, 16'd8);
    wr(8'd10, 16'd3);
    tick();
    wr(8'd8, 16'h000D);
    repeat (3) smp();
    trg();
    chk("post_trig", 32'(bus.triggered), 32'd1);
    smp();
    smp();
    wr(8'd8, 16'h000E);
    chk_idle("stop_post");
    tick();
    chk("stop_post_hold", 32'(bus.busy), 32'd0);

    // Only ch2 enabled: num=2, pre=0
    wr(8'd9, 16'd2);
    wr(8'd10, 16'd0);
    tick();
    wr(8'd8, 16'h0009);
    tick();
    chk("ch2_we", 32'(bus.we), 32'd1);
    trg();
    smp();
    smp();
    chk("ch2_we_off", 32'(bus.we), 32'd0);
    chk("ch2_rq", 32'({bus.rqst_data_ch1, bus.rqst_data_ch2}), 32'b01);
    rq1_cnt = 0; ack1_seen = 0;
    for (int i = 0; i < 2; i++) begin
      bus.ch2_tx_rdy = 1'b1; bus.ch2_tx_data = 8'h60 + 8'(i);
      bus.ch2_tx_eof = (i == 1); bus.tx_ack = 1'b1;
      #1;
      rq1_cnt += int'(bus.rqst_data_ch1); ack1_seen += int'(bus.ch1_tx_ack);
      chk($sformatf("only2_b%0d_data", i), 32'(bus.tx_data), 32'h60 + 32'(i));
      chk($sformatf("only2_b%0d_eof", i),  32'(bus.tx_eof), (i == 1) ? 32'd1 : 32'd0);
      tick();
    end
    clr_tx();
    #1;
    chk("only2_rq1", 32'(rq1_cnt), 32'd0);
    chk("only2_ack1", 32'(ack1_seen), 32'd0);
    chk_idle("done2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
